// File: rtl/cas_fsk_player.sv
// rtl/cas_fsk_player.sv - CAS tape image to CoCo cassette FSK waveform player
//
// Fetches bytes from the tape SRAM and plays them LSB-first as FSK cells:
// a 0 bit is one cycle of period 2*HALF0 clk, a 1 bit one cycle of 2*HALF1 clk.
//
// Ports:
//   clk       system clock (clk_sys)
//   reset_n   asynchronous active-low reset
//   en        motor relay; 1 = tape runs, 0 = freeze mid-cell
//   rewind    level; holds the tape at position 0
//   tape_len  number of valid bytes in the SRAM
//   ram_addr  SRAM byte address
//   ram_data  SRAM read data, valid 2 clk after ram_addr changes
//   data      FSK output (casdout)
//   playing   high while a bit cell is being emitted
//   eot       end of tape: idle with ram_addr == tape_len

module cas_fsk_player #(
    parameter int unsigned HALF0 = 23864,
    parameter int unsigned HALF1 = 11932,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          rewind,
    input  logic [AW-1:0] tape_len,
    output logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_data,
    output logic          data,
    output logic          playing,
    output logic          eot
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_LOW   = 3'd4;

    localparam logic [15:0] PER0 = 16'(HALF0);
    localparam logic [15:0] PER1 = 16'(HALF1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [7:0]  shreg;
    logic [2:0]  bitcnt;
    logic        wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ram_addr <= '0;
            data     <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            wait_cnt <= 1'b0;
        end else if (rewind) begin
            // Rewind overrides motor state and the end-of-byte increment.
            state    <= ST_IDLE;
            ram_addr <= '0;
            data     <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            wait_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // tape_len only matters here, so a mid-byte change never aborts a byte.
                    if (en && (ram_addr != tape_len)) begin
                        state    <= ST_FETCH;
                        wait_cnt <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // Two cycles here plus the IDLE cycle cover the SRAM read latency.
                    if (en) begin
                        if (wait_cnt) begin
                            state <= ST_LOAD;
                        end
                        wait_cnt <= ~wait_cnt;
                    end
                end
                ST_LOAD: begin
                    shreg  <= ram_data;
                    bitcnt <= '0;
                    cnt    <= ram_data[0] ? PER1 : PER0;
                    data   <= 1'b1;
                    state  <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (en) begin
                        if (cnt == 16'd1) begin
                            cnt   <= shreg[0] ? PER1 : PER0;
                            data  <= 1'b0;
                            state <= ST_LOW;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                ST_LOW: begin
                    if (en) begin
                        if (cnt == 16'd1) begin
                            if (bitcnt != 3'd7) begin
                                // shreg[1] becomes the next bit after the shift.
                                shreg  <= shreg >> 1;
                                bitcnt <= bitcnt + 3'd1;
                                cnt    <= shreg[1] ? PER1 : PER0;
                                data   <= 1'b1;
                                state  <= ST_HIGH;
                            end else begin
                                ram_addr <= ram_addr + AW'(1);
                                state    <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    data  <= 1'b0;
                end
            endcase
        end
    end

    assign playing = (state == ST_HIGH) || (state == ST_LOW);
    assign eot     = (state == ST_IDLE) && (ram_addr == tape_len);

endmodule

// File: tb/tb_cas_fsk_player.sv
// tb/tb_cas_fsk_player.sv - scoreboard testbench for cas_fsk_player
module tb_cas_fsk_player;

    localparam int HALF0 = 4;
    localparam int HALF1 = 2;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic          rewind;
    logic [AW-1:0] tape_len;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          data;
    logic          playing;
    logic          eot;

    logic [7:0]  mem [0:255];
    logic [7:0]  rd1;
    logic [31:0] exp_q [$];
    logic [15:0] hcnt = '0;
    logic [15:0] lcnt = '0;
    logic        abort = 1'b0;
    logic        saw_playing = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    cas_fsk_player #(.HALF0(HALF0), .HALF1(HALF1), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .rewind   (rewind),
        .tape_len (tape_len),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .data     (data),
        .playing  (playing),
        .eot      (eot)
    );

    always #5 clk = ~clk;

    // Tape SRAM with two-cycle read latency.
    always @(posedge clk) begin
        rd1      <= mem[ram_addr];
        ram_data <= rd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cell(input int hi, input int lo);
        logic [15:0] h;
        logic [15:0] l;
        h = 16'(hi);
        l = 16'(lo);
        exp_q.push_back({h, l});
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (b[i]) push_cell(HALF1, HALF1);
            else      push_cell(HALF0, HALF0);
        end
    endtask

    task automatic finish_cell();
        if (exp_q.size() == 0) check("cell_unexpected", {hcnt, lcnt}, 32'hFFFF_FFFF);
        else                   check("cell", {hcnt, lcnt}, exp_q.pop_front());
        hcnt = '0;
        lcnt = '0;
    endtask

    // Measures each cell as (high clk, low clk) and scores it against the queue.
    always @(negedge clk) begin
        if (playing) saw_playing = 1'b1;
        if (playing && data) begin
            if (lcnt != 0) finish_cell();
            hcnt++;
        end else if (playing) begin
            lcnt++;
        end else if (hcnt != 0 || lcnt != 0) begin
            if (abort) begin
                hcnt = '0;
                lcnt = '0;
            end else begin
                finish_cell();
            end
        end
    end

    task automatic wait_eot(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!eot && n < budget);
        check("eot_reached", {31'd0, eot}, 32'd1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01;
        mem[1] = 8'hAA;
        mem[2] = 8'h55;
        mem[3] = 8'h00;
        mem[4] = 8'h35;
        mem[5] = 8'h00;

        // Reset with an empty tape and the motor on.
        reset_n  = 1'b0;
        en       = 1'b1;
        rewind   = 1'b0;
        tape_len = '0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_data", {31'd0, data}, 0);
        check("rst_playing", {31'd0, playing}, 0);
        check("rst_eot", {31'd0, eot}, 1);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("empty_eot", {31'd0, eot}, 1);
        check("empty_addr", 32'(ram_addr), 0);
        check("empty_never_played", {31'd0, saw_playing}, 0);

        // Single byte 0x01, also measuring first-rise latency.
        push_byte(8'h01);
        tape_len = 8'd1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (data !== 1'b1 && n < 20);
        check("latency", n, 4);
        wait_eot(500);
        check("b01_addr", 32'(ram_addr), 1);
        check("b01_data", {31'd0, data}, 0);

        // 0xAA then 0x55.
        push_byte(8'hAA);
        push_byte(8'h55);
        tape_len = 8'd3;
        wait_eot(1000);
        check("aa55_addr", 32'(ram_addr), 3);

        // Pause for 10 clk inside the first HIGH half of byte 0x00.
        push_cell(HALF0 + 10, HALF0);
        for (int i = 1; i < 8; i++) push_cell(HALF0, HALF0);
        tape_len = 8'd4;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (data !== 1'b1 && n < 20);
        check("pause_start", {31'd0, data}, 1);
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("pause_data", {31'd0, data}, 1);
        check("pause_addr", 32'(ram_addr), 3);
        en = 1'b1;
        wait_eot(1000);
        check("pause_end_addr", 32'(ram_addr), 4);

        // Rewind during bit 5 of byte 0x35, with en dropping on the same edge.
        for (int i = 0; i < 5; i++) begin
            if (mem[4][i]) push_cell(HALF1, HALF1);
            else           push_cell(HALF0, HALF0);
        end
        tape_len = 8'd5;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(exp_q.size() == 0 && data === 1'b1) && n < 400);
        check("rw_reach_bit5", {31'd0, n < 400}, 1);
        rewind = 1'b1;
        abort  = 1'b1;
        en     = 1'b0;
        @(negedge clk);
        #1;
        check("rw_addr", 32'(ram_addr), 0);
        check("rw_data", {31'd0, data}, 0);
        check("rw_playing", {31'd0, playing}, 0);
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("rw_hold_playing", {31'd0, playing}, 0);
        check("rw_hold_addr", 32'(ram_addr), 0);
        check("rw_hold_eot", {31'd0, eot}, 0);
        for (int i = 0; i < 5; i++) push_byte(mem[i]);
        abort  = 1'b0;
        rewind = 1'b0;
        wait_eot(3000);
        check("rw_replay_addr", 32'(ram_addr), 5);

        // Asynchronous reset in the middle of a LOW half.
        abort    = 1'b1;
        tape_len = 8'd6;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(playing === 1'b1 && data === 1'b0) && n < 100);
        check("ar_reach_low", {31'd0, n < 100}, 1);
        reset_n = 1'b0;
        #1;
        check("ar_addr", 32'(ram_addr), 0);
        check("ar_playing", {31'd0, playing}, 0);
        check("ar_data", {31'd0, data}, 0);
        tape_len = 8'd1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        push_byte(mem[0]);
        reset_n = 1'b1;
        wait_eot(500);
        check("ar_replay_addr", 32'(ram_addr), 1);
        check("ar_replay_data", {31'd0, data}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
